ticker_bank: RTL and testbench

Multi-channel programmable tick generator, and the parametrised successor to the single fixed-period ticker. It holds NUM_CH independent timer channels, each with a runtime-writable period and a periodic or one-shot mode, all driven by one shared prescaler. Each channel emits single-cycle tick pulses and a sticky interrupt-pending flag. It sits beside the counter and display logic as the common time base for blink, debounce and refresh rates.

---
 rtl/ticker_pkg.sv | 17 +
 rtl/ticker_channel.sv | 112 +++++++++++
 rtl/ticker_bank.sv | 73 +++++++
 tb/tb_ticker_bank.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ticker_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package ticker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Index width for a bank of n entries; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ticker_channel.sv
// One timer channel: shadow/active configuration, count, run FSM, tick and
// sticky pending flag. Advances only on the shared prescaler strobe.
module ticker_channel
  import ticker_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic             mode_i,
  input  logic             irq_clr_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             pending_o
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic [WIDTH-1:0] active_period_q, active_period_d;
  logic             active_mode_q, active_mode_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      count_q         <= '0;
      shadow_period_q <= '1;
      shadow_mode_q   <= MODE_PERIODIC;
      active_period_q <= '0;
      active_mode_q   <= MODE_PERIODIC;
      tick_q          <= 1'b0;
      pending_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      shadow_period_q <= shadow_period_d;
      shadow_mode_q   <= shadow_mode_d;
      active_period_q <= active_period_d;
      active_mode_q   <= active_mode_d;
      tick_q          <= tick_d;
      pending_q       <= pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    shadow_period_d = shadow_period_q;
    shadow_mode_d   = shadow_mode_q;
    active_period_d = active_period_q;
    active_mode_d   = active_mode_q;
    tick_d          = 1'b0;
    // A tick landing together with a clear keeps the flag set.
    pending_d       = tick_q | (pending_q & ~irq_clr_i);

    // Reloads below read the _d shadow so a same-cycle write is picked up.
    if (wr_i) begin
      shadow_period_d = period_i;
      shadow_mode_d   = mode_i;
    end

    unique case (state_q)
      IDLE: begin
        if (stop_i) begin
          count_d = '0;
        end else if (start_i) begin
          state_d         = RUN;
          count_d         = '0;
          active_period_d = shadow_period_d;
          active_mode_d   = shadow_mode_d;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start_i) begin
          count_d         = '0;
          active_period_d = shadow_period_d;
          active_mode_d   = shadow_mode_d;
        end else if (strobe_i) begin
          if (count_q == active_period_q) begin
            tick_d  = 1'b1;
            count_d = '0;
            if (active_mode_q == MODE_ONESHOT) begin
              state_d = IDLE;
            end else begin
              active_period_d = shadow_period_d;
              active_mode_d   = shadow_mode_d;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick_o    = tick_q;
  assign busy_o    = (state_q == RUN);
  assign pending_o = pending_q;

endmodule

// File: rtl/ticker_bank.sv
// Bank of independent programmable tick channels sharing one prescaler;
// irq is the OR of all pending flags.
module ticker_bank
  import ticker_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]              cfg_period,
  input  logic                          cfg_oneshot,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             stop,
  input  logic [NUM_CH-1:0]             irq_clr,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             pending,
  output logic                          irq
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);
  localparam int unsigned PS_W = ch_idx_w(PRESCALE);

  logic [PS_W-1:0] prescale_q, prescale_d;
  logic            strobe_c;

  assign strobe_c = enable && (prescale_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  // Free-running divider; only enable gates it, channel starts never touch it.
  always_comb begin
    prescale_d = prescale_q;
    if (enable) begin
      prescale_d = strobe_c ? '0 : prescale_q + PS_W'(1);
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic wr_c;
    // Out-of-range channel numbers match no instance and are dropped.
    assign wr_c = cfg_we && (cfg_ch == CH_W'(i));

    ticker_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .strobe_i (strobe_c),
      .start_i  (start[i]),
      .stop_i   (stop[i]),
      .wr_i     (wr_c),
      .period_i (cfg_period),
      .mode_i   (cfg_oneshot),
      .irq_clr_i(irq_clr[i]),
      .tick_o   (tick[i]),
      .busy_o   (busy[i]),
      .pending_o(pending[i])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_ticker_bank.sv
// Self-checking bench: two banks (prescale 1 and 4) share stimulus; directed
// scenarios use hand-derived tick times, the random run uses a reference model.
module tb_ticker_bank;

  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_period;
  logic           cfg_oneshot;
  logic [NCH-1:0] start, stop, irq_clr;
  logic [NCH-1:0] tick0, busy0, pend0, tick1, busy1, pend1;
  logic           irq0, irq1;

  int total = 0;
  int bad   = 0;

  ticker_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .irq_clr(irq_clr), .tick(tick0), .busy(busy0), .pending(pend0), .irq(irq0));

  ticker_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .irq_clr(irq_clr), .tick(tick1), .busy(busy1), .pending(pend1), .irq(irq1));

  always #5 clk = ~clk;

  // Reference model: enabled-cycle phase per bank, strobes counted per channel.
  int m_phase [2];
  int m_sh_p  [2][NCH];
  bit m_sh_m  [2][NCH];
  int m_act_p [2][NCH];
  bit m_act_m [2][NCH];
  int m_cnt   [2][NCH];
  bit m_run   [2][NCH];
  bit m_tick  [2][NCH];
  bit m_pend  [2][NCH];

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_sh_p[d][c] = (1 << W) - 1; m_sh_m[d][c] = 1'b0;
        m_act_p[d][c] = 0; m_act_m[d][c] = 1'b0; m_cnt[d][c] = 0;
        m_run[d][c] = 1'b0; m_tick[d][c] = 1'b0; m_pend[d][c] = 1'b0;
      end
    end
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      bit strobe;
      strobe = enable && (m_phase[d] == ps_of(d) - 1);
      if (enable) m_phase[d] = (m_phase[d] + 1) % ps_of(d);
      for (int c = 0; c < NCH; c++) begin
        int  np; bit nm; bit nt;
        m_pend[d][c] = m_tick[d][c] || (m_pend[d][c] && !irq_clr[c]);
        np = m_sh_p[d][c]; nm = m_sh_m[d][c];
        if (cfg_we && int'(cfg_ch) == c) begin np = int'(cfg_period); nm = cfg_oneshot; end
        nt = 1'b0;
        if (stop[c]) begin
          m_run[d][c] = 1'b0; m_cnt[d][c] = 0;
        end else if (start[c]) begin
          m_run[d][c] = 1'b1; m_cnt[d][c] = 0; m_act_p[d][c] = np; m_act_m[d][c] = nm;
        end else if (m_run[d][c] && strobe) begin
          if (m_cnt[d][c] == m_act_p[d][c]) begin
            nt = 1'b1; m_cnt[d][c] = 0;
            if (m_act_m[d][c]) m_run[d][c] = 1'b0;
            else begin m_act_p[d][c] = np; m_act_m[d][c] = nm; end
          end else begin
            m_cnt[d][c] = m_cnt[d][c] + 1;
          end
        end
        m_tick[d][c] = nt;
        m_sh_p[d][c] = np; m_sh_m[d][c] = nm;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] mv(input int d, input int which);
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[c] = (which == 0) ? m_tick[d][c] : (which == 1) ? m_run[d][c] : m_pend[d][c];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    start = '0; stop = '0; irq_clr = '0; cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_oneshot = 1'b0; start = '0; stop = '0; irq_clr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic write_cfg(input int ch, input int p, input bit os);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = W'(p); cfg_oneshot = os;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({tick0, busy0, pend0, irq0, tick1, busy1, pend1, irq1} !== '0) begin
      bad++; $display("FAIL reset_values got=%0h exp=0",
                      {tick0, busy0, pend0, irq0, tick1, busy1, pend1, irq1});
    end
    write_cfg(0, 3, 1'b0); step();
    start = 3'b001; step();
    for (int k = 1; k <= 8; k++) step();
    total++;
    if (tick0[0] !== 1'b1 || pend0[0] !== 1'b1) begin
      bad++; $display("FAIL reset_prerun tick=%b pend=%b exp=1,1", tick0[0], pend0[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({tick0, busy0, pend0, irq0} !== '0) begin
      bad++; $display("FAIL reset_async got=%0h exp=0", {tick0, busy0, pend0, irq0});
    end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (tick0 !== '0 || busy0 !== '0) begin
        bad++; $display("FAIL reset_quiet k=%0d tick=%b busy=%b exp=0,0", k, tick0, busy0);
      end
    end
  endtask

  task automatic test_periodic();
    do_reset();
    write_cfg(0, 4, 1'b0); step();
    start = 3'b001; step();
    for (int k = 1; k <= 16; k++) begin
      step();
      total++;
      if (tick0[0] !== ((k % 5) == 0) || pend0[0] !== (k >= 6)) begin
        bad++; $display("FAIL periodic k=%0d tick=%b pend=%b exp=%b,%b",
                        k, tick0[0], pend0[0], (k % 5) == 0, k >= 6);
      end
    end
    total++;
    if (irq0 !== 1'b1) begin bad++; $display("FAIL periodic_irq got=%b exp=1", irq0); end
    stop = 3'b001; irq_clr = 3'b001; step();
    total++;
    if (pend0[0] !== 1'b0 || irq0 !== 1'b0 || busy0[0] !== 1'b0) begin
      bad++; $display("FAIL periodic_clear pend=%b irq=%b busy=%b exp=0,0,0",
                      pend0[0], irq0, busy0[0]);
    end
  endtask

  task automatic test_oneshot();
    int nticks = 0;
    int first  = 0;
    do_reset();
    write_cfg(1, 2, 1'b1); step();
    start = 3'b010; step();
    total++;
    if (busy1[1] !== 1'b1) begin bad++; $display("FAIL oneshot_busy got=%b exp=1", busy1[1]); end
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick1[1] === 1'b1) begin
        nticks++;
        if (first == 0) first = k;
        total++;
        if (busy1[1] !== 1'b0) begin
          bad++; $display("FAIL oneshot_busy_drop k=%0d busy=%b exp=0", k, busy1[1]);
        end
      end
    end
    total++;
    if (nticks != 1 || first < 9 || first > 12) begin
      bad++; $display("FAIL oneshot_count ticks=%0d at=%0d exp=1 in 9..12", nticks, first);
    end
  endtask

  task automatic test_shadow();
    do_reset();
    write_cfg(2, 5, 1'b0); step();
    start = 3'b100; step();
    for (int k = 1; k <= 14; k++) begin
      bit exp_t;
      if (k == 2) write_cfg(2, 1, 1'b0);
      step();
      exp_t = (k == 6) || (k > 6 && ((k - 6) % 2) == 0);
      total++;
      if (tick0[2] !== exp_t) begin
        bad++; $display("FAIL shadow k=%0d tick=%b exp=%b", k, tick0[2], exp_t);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    write_cfg(0, 1, 1'b0); step();
    start = 3'b001; stop = 3'b001; step();
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (tick0[0] !== 1'b0 || busy0[0] !== 1'b0) begin
        bad++; $display("FAIL start_stop k=%0d tick=%b busy=%b exp=0,0", k, tick0[0], busy0[0]);
      end
    end
    write_cfg(0, 2, 1'b0); start = 3'b001; step();
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (tick0[0] !== ((k % 3) == 0)) begin
        bad++; $display("FAIL wr_start k=%0d tick=%b exp=%b", k, tick0[0], (k % 3) == 0);
      end
    end
    irq_clr = 3'b001; step();
    total++;
    if (pend0[0] !== 1'b1) begin bad++; $display("FAIL tick_clr got=%b exp=1", pend0[0]); end
    irq_clr = 3'b001; step();
    total++;
    if (pend0[0] !== 1'b0) begin bad++; $display("FAIL clr_after got=%b exp=0", pend0[0]); end
    stop = 3'b001; step();
  endtask

  task automatic test_edges();
    do_reset();
    write_cfg(1, 0, 1'b0); step();
    start = 3'b010; step();
    for (int k = 1; k <= 40; k++) begin
      bit en;
      en = 1'($urandom % 2);
      enable = en;
      step();
      total++;
      if (tick0[1] !== en) begin
        bad++; $display("FAIL p0_enable k=%0d tick=%b exp=%b", k, tick0[1], en);
      end
    end
    enable = 1'b1;

    do_reset();
    write_cfg(0, 255, 1'b0); step();
    start = 3'b001; step();
    for (int k = 1; k <= 256; k++) begin
      step();
      total++;
      if (tick0[0] !== (k == 256) || busy0[0] !== 1'b1) begin
        bad++; $display("FAIL pmax k=%0d tick=%b busy=%b exp=%b,1", k, tick0[0], busy0[0], k == 256);
      end
    end

    do_reset();
    write_cfg(3, 0, 1'b0); step();
    start = 3'b111; step();
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (tick0 !== '0) begin
        bad++; $display("FAIL cfg_oob k=%0d tick=%b exp=000", k, tick0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      enable      = ($urandom % 8) != 0;
      cfg_we      = ($urandom % 4) == 0;
      cfg_ch      = 2'($urandom % 4);
      cfg_period  = W'($urandom % 6);
      cfg_oneshot = 1'($urandom % 2);
      for (int c = 0; c < NCH; c++) begin
        start[c]   = ($urandom % 16) == 0;
        stop[c]    = ($urandom % 32) == 0;
        irq_clr[c] = ($urandom % 8) == 0;
      end
      step();
      for (int d = 0; d < 2; d++) begin
        logic [NCH-1:0] gt, gb, gp;
        logic           gi;
        gt = d ? tick1 : tick0; gb = d ? busy1 : busy0;
        gp = d ? pend1 : pend0; gi = d ? irq1 : irq0;
        total++;
        if (gt !== mv(d, 0)) begin
          bad++; $display("FAIL rand_tick d=%0d n=%0d got=%b exp=%b", d, n, gt, mv(d, 0));
        end
        total++;
        if (gb !== mv(d, 1)) begin
          bad++; $display("FAIL rand_busy d=%0d n=%0d got=%b exp=%b", d, n, gb, mv(d, 1));
        end
        total++;
        if (gp !== mv(d, 2)) begin
          bad++; $display("FAIL rand_pend d=%0d n=%0d got=%b exp=%b", d, n, gp, mv(d, 2));
        end
        total++;
        if (gi !== (|mv(d, 2))) begin
          bad++; $display("FAIL rand_irq d=%0d n=%0d got=%b exp=%b", d, n, gi, |mv(d, 2));
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_shadow();
    test_simultaneous();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
